// File: rtl/wide_word_buffer.sv
// Elastic FWFT buffer behind the serial-to-parallel packer. It absorbs consumer stalls
// for up to DEPTH words. The packer cannot be stalled, so overflow words are dropped and counted.

module wide_word_entry #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
endmodule

module wide_word_buffer #(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 4,
  parameter  int DROP_WIDTH = 8,
  localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [DROP_WIDTH-1:0] drop_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [DEPTH-1:0]                 wr_en;
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
  logic                             push, pop, drop;

  // count alone decides full/empty; pointers are free-running modulo DEPTH
  assign empty     = (count == '0);
  assign full      = (count == CNT_WIDTH'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < DEPTH; i++)
      wr_en[i] = push && !clear && (wr_ptr == PTR_W'(i));
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    wide_word_entry #(.DATA_WIDTH(DATA_WIDTH)) u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en[i]),
      .d     (in_data),
      .q     (mem[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // drop bookkeeping; the counter sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (!(&drop_count)) drop_count <= drop_count + DROP_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_wide_word_buffer.sv
// Directed bench for wide_word_buffer: FWFT order, fill/wrap, full+pop, overflow
// saturation, async reset mid-stream and clear priority.
module tb_wide_word_buffer;
  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic        out_valid, empty, full, overflow;
  logic [2:0]  count;
  logic [7:0]  drop_count;

  int n_chk  = 0;
  int n_fail = 0;

  wide_word_buffer #(.DATA_WIDTH(64), .DEPTH(4), .DROP_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_drop"}, 64'(drop_count), 64'd0);
  endtask

  logic [63:0] fw [3];
  logic [63:0] wr [6];
  logic [63:0] bw [5];

  initial begin
    fw = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333};
    wr = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5};
    bw = '{64'hB0, 64'hB1, 64'hB2, 64'hB3, 64'hB4};
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) tick();
    chk_idle("rst");
    chk("rst_data", out_data, 64'd0);
    rst_n = 1'b1;
    tick();

    // FWFT streaming with consumer always ready
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = fw[0];
    #1 chk("fwft_nobypass", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      in_data = fw[i];
      tick();
      chk($sformatf("fwft_valid%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("fwft_data%0d", i), out_data, fw[i]);
      chk($sformatf("fwft_cnt%0d", i), 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("fwft_drained", 64'(empty), 64'd1);

    // fill, partial drain, refill across the pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(wr[i]);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_cnt", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("wrap_rd%0d", i), out_data, wr[i]);
      tick();
    end
    out_ready = 1'b0;
    chk("wrap_cnt2", 64'(count), 64'd2);
    for (int i = 4; i < 6; i++) push_word(wr[i]);
    chk("wrap_cnt4", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 2; i < 6; i++) begin
      chk($sformatf("wrap_rd%0d", i), out_data, wr[i]);
      tick();
    end
    chk("wrap_empty", 64'(empty), 64'd1);

    // full with simultaneous pop accepts the word
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(bw[i]);
    out_ready = 1'b1;
    push_word(bw[4]);
    out_ready = 1'b0;
    chk("fullpop_cnt", 64'(count), 64'd4);
    chk("fullpop_ovf", 64'(overflow), 64'd0);
    chk("fullpop_head", out_data, bw[1]);

    // overflow: 300 drops saturate the counter at 255
    in_valid = 1'b1;
    in_data  = 64'hDEAD;
    tick();
    chk("ovf_first", 64'(overflow), 64'd1);
    chk("ovf_drop1", 64'(drop_count), 64'd1);
    repeat (299) tick();
    in_valid = 1'b0;
    chk("ovf_sat", 64'(drop_count), 64'd255);
    chk("ovf_cnt", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("ovf_rd%0d", i), out_data, bw[i]);
      tick();
    end
    out_ready = 1'b0;
    chk("ovf_empty", 64'(empty), 64'd1);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // asynchronous reset with 3 words held
    for (int i = 0; i < 3; i++) push_word(64'hC0 + 64'(i));
    chk("ar_cnt3", 64'(count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk_idle("ar");
    chk("ar_data", out_data, 64'd0);
    #2 rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 64'hE0;
    #1 chk("ar_nobypass", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("ar_lat1_valid", 64'(out_valid), 64'd1);
    chk("ar_lat1_data", out_data, 64'hE0);

    // clear beats push/pop/drop in the same cycle
    push_word(64'hE1);
    push_word(64'hE2);
    push_word(64'hE3);
    push_word(64'hE4);
    push_word(64'hE5);
    chk("clr_pre_ovf", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("clr_pre_cnt", 64'(count), 64'd3);
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hBAD;
    out_ready = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_idle("clr");
    push_word(64'hF0);
    chk("clr_next_data", out_data, 64'hF0);
    chk("clr_next_cnt", 64'(count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
